// File: rtl/mikro_defs.sv
// Constants shared by instruction_fetch and instruction_decoder: instruction width,
// the NOP/HALT codes and the fetch sequencer state encoding.
package mikro_defs;

    localparam int INSTR_WIDTH = 6;

    // Both codes have instruction[5:2] >= 8, which the decoder executes as a no-op.
    localparam logic [INSTR_WIDTH-1:0] NOP  = 6'b100000;
    localparam logic [INSTR_WIDTH-1:0] HALT = 6'b111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: synchronous load-zero on clear, increment with wrap, async reset.
// Also exposes the wrapped successor address for back-to-back ROM reads.
module program_counter #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus1
);

    assign pc_plus1 = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clear) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program sequencer: reads a 1-cycle-latency ROM at the PC and issues one
// instruction per clock while running, single-steps on request, stops on HALT.
module instruction_fetch
    import mikro_defs::*;
#(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = mikro_defs::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   clear,
    output logic                   mem_rd_en,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
);

    fetch_state_t          state, state_next;
    logic                  step_mode, step_mode_next;
    logic                  rd_en, inc;
    logic [PC_WIDTH-1:0]   rd_addr, addr_q, pc_plus1;

    program_counter #(
        .PC_WIDTH(PC_WIDTH)
    ) u_program_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .inc      (inc),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_mode <= 1'b0;
            addr_q    <= '0;
        end else begin
            state     <= state_next;
            step_mode <= step_mode_next;
            if (rd_en) begin
                addr_q <= rd_addr;
            end
        end
    end

    always_comb begin
        state_next     = state;
        step_mode_next = step_mode;
        rd_en          = 1'b0;
        rd_addr        = pc;
        inc            = 1'b0;
        instruction    = NOP;
        instr_valid    = 1'b0;
        halted         = 1'b0;

        unique case (state)
            IDLE: begin
                if (run || step) begin
                    state_next     = PRIME;
                    step_mode_next = step & ~run;
                end
            end
            PRIME: begin
                rd_en      = 1'b1;
                rd_addr    = pc;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (mem_rdata == HALT) begin
                    halted     = 1'b1;
                    state_next = HALTED;
                end else begin
                    instruction = mem_rdata;
                    instr_valid = 1'b1;
                    inc         = 1'b1;
                    // Prefetch the successor now so the next word lands without a bubble.
                    if (run && !step_mode) begin
                        rd_en   = 1'b1;
                        rd_addr = pc_plus1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Clear overrides everything; suppressing the read discards any in-flight word.
        if (clear) begin
            state_next = IDLE;
            rd_en      = 1'b0;
            inc        = 1'b0;
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_en ? rd_addr : addr_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Program sequencer that feeds 6-bit instruction words to instruction_decoder; it is the producing end of the decoder's instruction bus.
- Owns the program counter (PC) and reads a synchronous program ROM with 1-cycle read latency.
- Issues up to one instruction per clock while running, and supports single-step.
- Stops on the HALT code; drives a harmless NOP whenever no instruction is being issued.

Parameters:
- PC_WIDTH, 4, address width of the program ROM (2^PC_WIDTH words).
- INSTR_WIDTH, 6, instruction width; fixed at 6, must match instruction_decoder.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; fetch continuously while high.
- step  input  1  one-cycle pulse; fetch and issue exactly one instruction.
- clear  input  1  synchronous; PC<=0, abort in-flight fetch, leave HALTED.
- mem_rd_en  output  1  ROM read strobe.
- mem_addr  output  PC_WIDTH  ROM read address.
- mem_rdata  input  INSTR_WIDTH  ROM data, valid the cycle after mem_rd_en.
- instruction  output  INSTR_WIDTH  to decoder; NOP when instr_valid=0.
- instr_valid  output  1  instruction is being issued this cycle.
- pc  output  PC_WIDTH  current PC (address of the next instruction to issue).
- halted  output  1  HALT reached.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clock:
  - state=IDLE, pc=0;
  - mem_rd_en=0, mem_addr=0;
  - instruction=NOP (6'b100000), instr_valid=0, halted=0.
- NOP 6'b100000 and HALT 6'b111111 both have instruction[5:2]>=8, which the decoder treats as no-op.
- States and transitions:
  - IDLE: waits for a start.
    - run=1 or step=1 -> PRIME. If both are high, run wins.
    - step_mode flag is latched = (step & ~run).
  - PRIME: mem_rd_en=1, mem_addr=pc -> ISSUE.
  - ISSUE: mem_rdata is valid this cycle.
    - If mem_rdata==HALT: instr_valid=0, instruction=NOP, pc unchanged (points at HALT) -> HALTED.
    - Otherwise: instruction=mem_rdata (combinational pass-through), instr_valid=1, pc<=pc+1 mod 2^PC_WIDTH.
    - If run=1 and not step_mode: mem_rd_en=1, mem_addr=pc+1 (wrapped) -> ISSUE again. Steady state is one instruction per clock.
    - Else -> IDLE.
  - HALTED: halted=1, no reads.
    - Ignores run and step.
    - Exits only on clear or reset.
- Latency: a start sampled at cycle N gives the first instr_valid at N+2.
- run dropped during PRIME: the in-flight word is still issued, then IDLE.
- step while not in IDLE: ignored; no queueing.
- clear: highest priority in every state.
  - Next cycle: state=IDLE, pc=0, halted=0, instr_valid=0.
  - An outstanding ROM read is discarded.
- PC wrap: 2^PC_WIDTH-1 -> 0 with no gap in instr_valid.
- mem_addr holds its last value when mem_rd_en=0.

Decomposition:
- Package/header mikro_defs:
  - NOP and HALT localparams;
  - state encoding IDLE=0, PRIME=1, ISSUE=2, HALTED=3;
  - INSTR_WIDTH.
- The decoder should share the same constants.
- One natural sub-module: program_counter, which handles load-zero on clear, increment with wrap, and async reset.

Test Plan:
- Reset: hold rst_n=0 mid-run -> immediately pc=0, instruction=6'b100000, instr_valid=0, mem_rd_en=0, halted=0.
- Continuous run:
  - ROM[0]=000101, ROM[1]=011100, ROM[2]=111111; run=1 from cycle 0.
  - Required: instr_valid at cycles 2,3 with instruction 000101, then 011100.
  - At cycle 4: halted=1, pc=2, instr_valid=0.
- Single step: step pulse in IDLE at pc=0 -> exactly one issue of ROM[0] at cycle +2, pc=1, back to IDLE. A second step during PRIME is ignored.
- Wrap: PC_WIDTH=4, ROM all 011101, run held 20 cycles -> pc goes 15->0 and instr_valid stays high without a gap.
- Clear:
  - clear during ISSUE -> next cycle instr_valid=0, pc=0, IDLE.
  - clear with run=1 in the same cycle -> clear wins.
  - clear in HALTED -> halted=0.
- run low at PRIME -> one instruction issued, then IDLE; pc advanced by exactly 1.
